// File: rtl/bcd_pkg.sv
// Shared constants, state type and elaboration helpers for the sequential BCD-to-binary converter.
package bcd_pkg;

  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned DIGIT_MAX   = 9;
  localparam int unsigned CORR_THRESH = 8;
  localparam int unsigned CORR_VAL    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Minimum width able to count 0..v-1, never less than one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((32'(1) << r) < v) r++;
    return r;
  endfunction

  // True when a bin_w-bit result can hold every value of a digits-wide BCD number.
  function automatic bit bcd_fits(input int unsigned bin_w, input int unsigned digits);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) p = p * 10;
    return (64'(1) << bin_w) >= p;
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Request/response bundle between the switch front end and the converter.
interface bcd_to_bin_seq_if #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [BIN_W-1:0]      bin_out;

  modport master (
    output start, bcd_in,
    input  busy, done, err, bin_out
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, err, bin_out
  );
endinterface

// File: rtl/bcd_sub3.sv
// Per-digit correction for reverse double-dabble: digits of 8 or more lose 3 after each right shift.
module bcd_sub3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout_c
);

  always_comb begin
    dout_c = din;
    if (din >= DIGIT_W'(CORR_THRESH)) dout_c = din - DIGIT_W'(CORR_VAL);
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one shift-right plus subtract-3 correction per clock.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
)(
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  bcd_to_bin_seq_if.slave  bus
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned CAT_W = BCD_W + BIN_W;
  localparam int unsigned CNT_W = clog2(BIN_W);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_CONV = 2'(CONV);
  localparam logic [1:0] ST_FIN  = 2'(FIN);

  if (!bcd_fits(BIN_W, DIGITS)) begin : g_param_check
    $error("bcd_to_bin_seq: BIN_W too narrow for DIGITS BCD digits");
  end

  logic [1:0]       state_q,   state_d;
  logic [BCD_W-1:0] bcd_q,     bcd_d;
  logic [BIN_W-1:0] bin_q,     bin_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             err_q,     err_d;
  logic [BIN_W-1:0] bin_out_q, bin_out_d;

  logic [CAT_W-1:0] cat_shift_c;
  logic [BCD_W-1:0] bcd_corr_c;
  logic             bcd_bad_c;

  // The BCD LSB falls into the binary MSB on every shift.
  assign cat_shift_c = {bcd_q, bin_q} >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_sub3 u_sub3 (
      .din    (cat_shift_c[BIN_W + g*DIGIT_W +: DIGIT_W]),
      .dout_c (bcd_corr_c[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_comb begin
    bcd_bad_c = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bus.bcd_in[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(DIGIT_MAX)) bcd_bad_c = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    bin_out_d = bin_out_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bcd_bad_c) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            bcd_d   = bus.bcd_in;
            bin_d   = '0;
            cnt_d   = CNT_W'(BIN_W - 1);
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = ST_CONV;
          end
        end
      end
      ST_CONV: begin
        bcd_d = bcd_corr_c;
        bin_d = cat_shift_c[BIN_W-1:0];
        if (cnt_q == '0) state_d = ST_FIN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_FIN: begin
        bin_out_d = bin_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      bin_out_q <= '0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      bin_out_q <= bin_out_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.bin_out = bin_out_q;

endmodule
